// File: rtl/sram_bank_arbiter_pkg.sv
// Shared parameters, requester indices and lock-state type
// for the multi_sram bank arbiter.
package sram_bank_arbiter_pkg;
  localparam int NUM_SRAMS      = 8;
  localparam int MAX_ADDR_WIDTH = 8;
  localparam int INT8_WIDTH     = 8;
  localparam int SRAM_WIDTH_O   = 8;
  localparam int N_REQ          = 6;
  localparam int LOCK_MAX       = 16;
  localparam int BANK_W         = $clog2(NUM_SRAMS);
  localparam int REQ_W          = $clog2(N_REQ);
  localparam int CNT_W          = $clog2(LOCK_MAX + 1);

  localparam int REQ_GEMM1  = 0;
  localparam int REQ_GEMM2  = 1;
  localparam int REQ_ELEM0  = 2;
  localparam int REQ_ELEM1  = 3;
  localparam int REQ_AXI_WR = 4;
  localparam int REQ_AXI_RD = 5;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_state_t;

  typedef logic signed [SRAM_WIDTH_O-1:0] sram_word_t;
endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester-side valid/ready bundle with read-response return.
// master = requesters, slave = arbiter.
interface sram_bank_arbiter_if;
  import sram_bank_arbiter_pkg::*;

  logic [N_REQ-1:0]                     req_valid;
  logic [N_REQ-1:0]                     req_we;
  logic [N_REQ-1:0]                     req_lock;
  logic [N_REQ-1:0][BANK_W-1:0]         req_bank;
  logic [N_REQ-1:0][MAX_ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0][INT8_WIDTH-1:0]     req_wdata;
  logic [N_REQ-1:0]                     req_ready;
  logic [N_REQ-1:0]                     rsp_valid;
  sram_word_t [N_REQ-1:0]               rsp_data;

  modport master (
    output req_valid, req_we, req_lock,
    output req_bank, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock,
    input  req_bank, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_bank_arbiter_rr.sv
// One bank: round-robin pointer, lock FSM and one-hot grant.
// A locked owner that stops requesting hands the bank back at once.
module rr_bank_arb
  import sram_bank_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] gnt
);
  lock_state_t      state_q, state_d;
  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [REQ_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] rr_gnt;
  logic [REQ_W-1:0] rr_idx;
  logic             rr_hit;
  logic             own_hit;

  always_comb begin : rr_search
    int j;
    j      = 0;
    rr_gnt = '0;
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr_q) + i) % N_REQ;
      if (!rr_hit && req[j]) begin
        rr_hit    = 1'b1;
        rr_idx    = REQ_W'(j);
        rr_gnt[j] = 1'b1;
      end
    end
  end

  assign own_hit = !rst && (state_q == LOCKED)
                   && req[owner_q];

  always_comb begin : fsm
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    unique case (1'b1)
      rst: ;
      own_hit: begin
        gnt[owner_q] = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (!lock[owner_q] ||
            cnt_d == CNT_W'(LOCK_MAX)) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
        if (rr_hit) begin
          gnt   = rr_gnt;
          ptr_d = rr_idx;
          if (lock[rr_idx]) begin
            state_d = LOCKED;
            owner_d = rr_idx;
            cnt_d   = CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ptr_q   <= REQ_W'(N_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/sram_bank_arbiter.sv
// Per-bank arbiter in front of multi_sram with tagged read return.
// Define SRAM_ARB_STATS_EN to add per-requester stall counters.
module sram_bank_arbiter
  import sram_bank_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  sram_bank_arbiter_if.slave     bus,
  output logic [NUM_SRAMS-1:0]   sram_en,
  output logic [NUM_SRAMS-1:0]   sram_we,
  output logic [NUM_SRAMS-1:0][MAX_ADDR_WIDTH-1:0] sram_addr,
  output logic [NUM_SRAMS-1:0][INT8_WIDTH-1:0]     sram_din,
  input  sram_word_t [NUM_SRAMS-1:0]               sram_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] stall_cnt
`endif
);
  logic [NUM_SRAMS-1:0][N_REQ-1:0] mask;
  logic [NUM_SRAMS-1:0][N_REQ-1:0] gnt;
  logic [N_REQ-1:0]                rd_pend_q;
  logic [N_REQ-1:0][BANK_W-1:0]    rd_bank_q;
  logic [N_REQ-1:0]                rsp_v;

  always_comb begin
    mask = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      for (int r = 0; r < N_REQ; r++)
        mask[b][r] = bus.req_valid[r] &&
          (bus.req_bank[r] == BANK_W'(b));
  end

  for (genvar b = 0; b < NUM_SRAMS; b++) begin : g_bank
    rr_bank_arb u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (mask[b]),
      .lock (bus.req_lock),
      .gnt  (gnt[b])
    );
  end

  // Grants are one-hot per bank, so an AND-OR mux suffices.
  always_comb begin
    sram_en       = '0;
    sram_we       = '0;
    sram_addr     = '0;
    sram_din      = '0;
    bus.req_ready = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      for (int r = 0; r < N_REQ; r++)
        if (gnt[b][r]) begin
          sram_en[b]       = 1'b1;
          sram_we[b]       = bus.req_we[r];
          sram_addr[b]     = bus.req_addr[r];
          sram_din[b]      = bus.req_wdata[r];
          bus.req_ready[r] = 1'b1;
        end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= '0;
      rd_bank_q <= '0;
    end else begin
      rd_pend_q <= bus.req_ready & ~bus.req_we;
      rd_bank_q <= bus.req_bank;
    end
  end

  always_comb begin
    rsp_v        = rd_pend_q & ~{N_REQ{rst}};
    bus.rsp_data = '0;
    for (int r = 0; r < N_REQ; r++)
      if (rsp_v[r])
        bus.rsp_data[r] = sram_dout[rd_bank_q[r]];
  end

  assign bus.rsp_valid = rsp_v;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++)
        if (bus.req_valid[r] && !bus.req_ready[r]
            && stall_cnt[r] != 16'hFFFF)
          stall_cnt[r] <= stall_cnt[r] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Randomized bench for sram_bank_arbiter with a bank-level
// reference model and a behavioural write-first multi_sram.
module tb_sram_bank_arbiter;
  import sram_bank_arbiter_pkg::*;

  localparam int DEPTH = 1 << MAX_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  sram_bank_arbiter_if bus();

  logic [NUM_SRAMS-1:0] sram_en, sram_we;
  logic [NUM_SRAMS-1:0][MAX_ADDR_WIDTH-1:0] sram_addr;
  logic [NUM_SRAMS-1:0][INT8_WIDTH-1:0]     sram_din;
  sram_word_t [NUM_SRAMS-1:0]               sram_dout;
`ifdef SRAM_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stall_cnt;
`endif

  sram_bank_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [7:0] init_val(int b, int a);
    return 8'(b * 37 + a * 11 + 5);
  endfunction

  logic [7:0] mem [NUM_SRAMS][DEPTH];
  bit         wr  [NUM_SRAMS][DEPTH];

  always @(posedge clk) begin
    for (int b = 0; b < NUM_SRAMS; b++) begin
      if (mem_clr) begin
        for (int a = 0; a < DEPTH; a++) wr[b][a] <= 1'b0;
      end else if (sram_en[b]) begin
        if (sram_we[b]) begin
          mem[b][sram_addr[b]] <= sram_din[b];
          wr[b][sram_addr[b]]  <= 1'b1;
          sram_dout[b]         <= sram_din[b];
        end else begin
          sram_dout[b] <= wr[b][sram_addr[b]] ?
            mem[b][sram_addr[b]] :
            init_val(b, int'(sram_addr[b]));
        end
      end
    end
  end

  // reference model state
  int         last_g [NUM_SRAMS];
  bit         lk_on  [NUM_SRAMS];
  int         lk_own [NUM_SRAMS];
  int         lk_n   [NUM_SRAMS];
  int         win    [NUM_SRAMS];
  logic [7:0] ref_mem [NUM_SRAMS][DEPTH];
  bit         pend   [N_REQ];
  logic [7:0] pend_d [N_REQ];
  int         stl    [N_REQ];
  logic [N_REQ-1:0] exp_ready;

  logic [N_REQ-1:0]     seen_ready, seen_rv;
  logic [NUM_SRAMS-1:0] seen_en;
  logic [7:0]           seen_rd [N_REQ];

  int n_cmp, n_bad;

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_SRAMS; b++) begin
      last_g[b] = N_REQ - 1;
      lk_on[b]  = 1'b0;
      lk_own[b] = 0;
      lk_n[b]   = 0;
    end
    for (int r = 0; r < N_REQ; r++) begin
      pend[r] = 1'b0;
      stl[r]  = 0;
    end
  endtask

  function automatic bit wants(int r, int b);
    return bus.req_valid[r] && int'(bus.req_bank[r]) == b;
  endfunction

  // Winner = locked owner if still asking, else the nearest
  // requester after the last winner in circular order.
  task automatic model_arb();
    exp_ready = '0;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      int best;
      win[b] = -1;
      best   = N_REQ;
      if (rst) continue;
      if (lk_on[b] && wants(lk_own[b], b)) begin
        win[b] = lk_own[b];
      end else begin
        for (int r = 0; r < N_REQ; r++) begin
          int d;
          d = (r - last_g[b] - 1 + 2 * N_REQ) % N_REQ;
          if (wants(r, b) && d < best) begin
            best   = d;
            win[b] = r;
          end
        end
      end
      if (win[b] >= 0) exp_ready[win[b]] = 1'b1;
    end
  endtask

  task automatic model_tick();
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < N_REQ; r++) begin
      pend[r] = 1'b0;
      if (bus.req_valid[r] && !exp_ready[r] && stl[r] < 16'hFFFF)
        stl[r]++;
    end
    for (int b = 0; b < NUM_SRAMS; b++) begin
      int r, a;
      if (win[b] < 0) begin
        lk_on[b] = 1'b0;
        continue;
      end
      r = win[b];
      a = int'(bus.req_addr[r]);
      if (bus.req_we[r]) begin
        ref_mem[b][a] = bus.req_wdata[r];
      end else begin
        pend[r]   = 1'b1;
        pend_d[r] = ref_mem[b][a];
      end
      if (lk_on[b] && r == lk_own[b]) begin
        lk_n[b]++;
        if (!bus.req_lock[r] || lk_n[b] == LOCK_MAX)
          lk_on[b] = 1'b0;
      end else begin
        lk_on[b] = bus.req_lock[r];
        lk_own[b] = r;
        lk_n[b]   = 1;
      end
      last_g[b] = r;
    end
  endtask

  task automatic step();
    logic [NUM_SRAMS-1:0] e_en, e_we;
    logic [N_REQ-1:0]     e_rv;
    @(negedge clk);
    model_arb();
    e_en = '0;
    e_we = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      if (win[b] >= 0) begin
        e_en[b] = 1'b1;
        e_we[b] = bus.req_we[win[b]];
      end
    for (int r = 0; r < N_REQ; r++)
      e_rv[r] = pend[r] && !rst;
    seen_ready = bus.req_ready;
    seen_rv    = bus.rsp_valid;
    seen_en    = sram_en;
    for (int r = 0; r < N_REQ; r++)
      seen_rd[r] = $unsigned(bus.rsp_data[r]);
    check_eq("req_ready", bus.req_ready, exp_ready);
    check_eq("sram_en", sram_en, e_en);
    check_eq("sram_we", sram_we, e_we);
    for (int b = 0; b < NUM_SRAMS; b++)
      if (win[b] >= 0) begin
        check_eq($sformatf("addr[%0d]", b), sram_addr[b],
                 bus.req_addr[win[b]]);
        check_eq($sformatf("din[%0d]", b), sram_din[b],
                 bus.req_wdata[win[b]]);
      end
    check_eq("rsp_valid", bus.rsp_valid, e_rv);
    for (int r = 0; r < N_REQ; r++)
      check_eq($sformatf("rsp_data[%0d]", r), seen_rd[r],
               e_rv[r] ? pend_d[r] : 8'h00);
`ifdef SRAM_ARB_STATS_EN
    for (int r = 0; r < N_REQ; r++)
      check_eq($sformatf("stall[%0d]", r), stall_cnt[r],
               stl[r]);
`endif
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_bank  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(int r, bit we, bit lk, int bank,
                         int addr, logic [7:0] d);
    bus.req_valid[r] = 1'b1;
    bus.req_we[r]    = we;
    bus.req_lock[r]  = lk;
    bus.req_bank[r]  = BANK_W'(bank);
    bus.req_addr[r]  = MAX_ADDR_WIDTH'(addr);
    bus.req_wdata[r] = d;
  endtask

  initial begin
    int run, g;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    mem_clr = 1'b1;
    idle();
    for (int b = 0; b < NUM_SRAMS; b++)
      for (int a = 0; a < DEPTH; a++)
        ref_mem[b][a] = init_val(b, a);
    model_reset();
    repeat (2) step();
    mem_clr = 1'b0;
    rst     = 1'b0;

    // two readers on bank 2
    set_req(0, 0, 0, 2, 5, 8'h00);
    set_req(1, 0, 0, 2, 9, 8'h00);
    step();
    check_eq("t1_c0_ready", seen_ready, 6'b000001);
    bus.req_valid[0] = 1'b0;
    step();
    check_eq("t1_c1_ready", seen_ready, 6'b000010);
    check_eq("t1_c1_rv", seen_rv, 6'b000001);
    check_eq("t1_c1_rd0", seen_rd[0], init_val(2, 5));
    idle();
    step();
    check_eq("t1_c2_rv", seen_rv, 6'b000010);
    check_eq("t1_c2_rd1", seen_rd[1], init_val(2, 9));

    // all six on bank 0
    for (int r = 0; r < N_REQ; r++)
      set_req(r, 0, 0, 0, r, 8'h00);
    for (int c = 0; c < 12; c++) begin
      step();
      g = -1;
      for (int r = 0; r < N_REQ; r++)
        if (seen_ready[r]) g = r;
      check_eq("rr_order", g, c % N_REQ);
    end
    idle();
    step();

    // parallel write bank 1 / read bank 3
    set_req(4, 1, 0, 1, 3, 8'h7F);
    set_req(2, 0, 0, 3, 3, 8'h00);
    step();
    check_eq("t3_ready", seen_ready, 6'b010100);
    idle();
    set_req(5, 0, 0, 1, 3, 8'h00);
    step();
    check_eq("t3_rd2", seen_rd[2], init_val(3, 3));
    idle();
    step();
    check_eq("t3_rd5", seen_rd[5], 8'h7F);

    // lock run on bank 4
    set_req(0, 0, 1, 4, 1, 8'h00);
    set_req(1, 0, 0, 4, 2, 8'h00);
    run = 0;
    for (int k = 0; k < LOCK_MAX; k++) begin
      step();
      if (seen_ready == 6'b000001) run++;
    end
    check_eq("lock_run", run, LOCK_MAX);
    step();
    check_eq("lock_release", seen_ready, 6'b000010);

    // reset during lock with read in flight
    set_req(2, 0, 0, 3, 7, 8'h00);
    step();
    rst = 1'b1;
    step();
    check_eq("rst_rv", seen_rv, '0);
    check_eq("rst_en", seen_en, '0);
    check_eq("rst_ready", seen_ready, '0);
    rst = 1'b0;
    idle();
    set_req(0, 0, 0, 4, 0, 8'h00);
    set_req(1, 0, 0, 4, 0, 8'h00);
    step();
    check_eq("rst_first", seen_ready, 6'b000001);

    // req3 stalled behind a lock for 7 cycles
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 0, 1, 5, 0, 8'h00);
    set_req(3, 0, 0, 5, 1, 8'h00);
    repeat (7) step();
    check_eq("stall_ready3", seen_ready[3], 1'b0);
`ifdef SRAM_ARB_STATS_EN
    check_eq("stall_cnt3", stall_cnt[3], 16'd7);
`endif
    idle();
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N_REQ; r++)
        if (!(bus.req_valid[r] && !seen_ready[r])) begin
          bus.req_valid[r] = ($urandom % 10) < 6;
          bus.req_we[r]    = $urandom_range(0, 1) == 1;
          bus.req_lock[r]  = ($urandom % 4) == 0;
          bus.req_bank[r]  = BANK_W'($urandom_range(0, 3));
          bus.req_addr[r]  =
            MAX_ADDR_WIDTH'($urandom_range(0, 15));
          bus.req_wdata[r] = 8'($urandom);
        end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
